// File: rtl/kernel_seq_pkg.sv
// kernel_seq_pkg: shared state encoding and register-file addresses for the kernel MAC sequencer.
package kernel_seq_pkg;
    typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, MAC, READ, DONE} state_t;
    localparam logic [3:0] R_KROW = 4'd12;
    localparam logic [3:0] R_PIX  = 4'd13;
    localparam logic [3:0] R_ACC  = 4'd14;
    localparam int         KDIM   = 3;
endpackage

// File: rtl/kernel_mac_sequencer.sv
// kernel_mac_sequencer: runs one 3x3 kernel MAC per start by sequencing register-file writes;
// the register file's own datapath does the accumulation into R14.
module kernel_mac_sequencer
    import kernel_seq_pkg::*;
#(
    parameter int BITS = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] krow0,
    input  logic [BITS-1:0] krow1,
    input  logic [BITS-1:0] krow2,
    output logic            pix_req,
    input  logic            pix_valid,
    input  logic [BITS-1:0] pix_data,
    output logic            rf_wrt_ena,
    output logic [3:0]      rf_addrs_rd,
    output logic [BITS-1:0] rf_wrt_data,
    output logic [3:0]      rf_addrs_rn,
    input  logic [BITS-1:0] rf_rn_data,
    output logic [BITS-1:0] result,
    output logic            done,
    output logic            busy
);
    state_t                     state, state_n;
    logic [1:0]                 row, row_n, col, col_n;
    logic [KDIM-1:0][BITS-1:0]  krows;
    logic [BITS-1:0]            pix_q;
    logic                       accept;

    assign accept = state == IDLE && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            krows  <= '0;
            pix_q  <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            if (accept) krows <= {krow2, krow1, krow0};
            if (state == WAIT && pix_valid && !abort) pix_q <= pix_data;
            if (state == READ && !abort) result <= rf_rn_data;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        if (abort && state != IDLE) state_n = IDLE;
        else case (state)
            IDLE: if (accept) begin
                state_n = CLR;
                row_n   = '0;
                col_n   = '0;
            end
            CLR:  state_n = LOAD;
            LOAD: begin
                state_n = WAIT;
                col_n   = '0;
            end
            WAIT: if (pix_valid) state_n = MAC;
            MAC:  if (col < 2'd2) begin
                col_n   = col + 2'd1;
                state_n = WAIT;
            end else if (row < 2'd2) begin
                row_n   = row + 2'd1;
                state_n = LOAD;
            end else state_n = READ;
            READ: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Write port is purely state-decoded; ABORT takes effect from the next state.
    assign rf_wrt_ena  = state == CLR || state == LOAD || state == MAC;
    assign rf_addrs_rd = state == CLR ? R_ACC : state == LOAD ? R_KROW : state == MAC ? R_PIX : 4'd0;
    assign rf_wrt_data = state == LOAD ? krows[row] : state == MAC ? pix_q : '0;
    assign rf_addrs_rn = state == READ ? R_ACC : 4'd0;
    assign pix_req     = state == WAIT;
    assign done        = state == DONE;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_kernel_mac_sequencer.sv
// tb_kernel_mac_sequencer: end-to-end bench pairing the sequencer with a behavioural register file.
module tb_kernel_mac_sequencer;
    import kernel_seq_pkg::*;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0, pix_valid = 0;
    logic [23:0] krow0 = 0, krow1 = 0, krow2 = 0, pix_data = 0;
    logic        pix_req, rf_wrt_ena, done, busy;
    logic [3:0]  rf_addrs_rd, rf_addrs_rn;
    logic [23:0] rf_wrt_data, rf_rn_data, result;
    int total = 0, bad = 0;

    kernel_mac_sequencer #(.BITS(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .krow0(krow0), .krow1(krow1), .krow2(krow2),
        .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
        .rf_wrt_ena(rf_wrt_ena), .rf_addrs_rd(rf_addrs_rd), .rf_wrt_data(rf_wrt_data),
        .rf_addrs_rn(rf_addrs_rn), .rf_rn_data(rf_rn_data),
        .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file with the R13-triggered multiply-accumulate datapath.
    logic [23:0] rf [16];
    initial for (int i = 0; i < 16; i++) rf[i] = '0;
    assign rf_rn_data = rf[rf_addrs_rn];
    always @(posedge clk) begin
        if (rf_wrt_ena) begin
            if (rf_addrs_rd == R_PIX) begin
                rf[13] <= rf_wrt_data;
                rf[14] <= rf[14] + (rf[12] == 24'd0 ? 24'($signed(rf_wrt_data) >>> 3)
                                                    : 24'(rf_wrt_data * rf[12][23:16]));
                rf[12] <= rf[12] << 8;
            end else rf[rf_addrs_rd] <= rf_wrt_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each kernel row is a list of 3 coefficients; while any remain nonzero the
    // pixel is multiplied by the current one, otherwise pixel/8 (arithmetic) is added.
    function automatic logic [23:0] ref_result(input logic [23:0] k [3], input logic [23:0] p [9]);
        logic [23:0] acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                logic [7:0] coefs [3];
                bit live = 0;
                for (int j = 0; j < 3; j++) coefs[j] = 8'((k[r] >> (16 - 8 * j)) & 24'hff);
                for (int j = c; j < 3; j++) if (coefs[j] != 0) live = 1;
                acc = acc + (live ? 24'(p[3*r+c] * coefs[c]) : 24'($signed(p[3*r+c]) >>> 3));
            end
        return acc;
    endfunction

    task automatic do_job(input logic [23:0] k [3], input logic [23:0] p [9], input int gap,
                          input bit hold, input logic [23:0] exp, input string tag);
        int cyc = 0, idx = 0, w = 0, n13 = 0, nclr = 0, nreq = 0, done_cyc = -1;
        krow0 = k[0]; krow1 = k[1]; krow2 = k[2];
        @(negedge clk);
        start = 1;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 0;
            if (cyc == 1) begin krow0 = $urandom; krow1 = $urandom; krow2 = $urandom; end
            if (rf_wrt_ena && rf_addrs_rd == R_PIX) n13++;
            if (rf_wrt_ena && rf_addrs_rd == R_ACC) nclr++;
            if (done) begin done_cyc = cyc; start = 0; end
            if (pix_req) begin
                nreq++;
                if (w < gap) begin pix_valid = 0; w++; end
                else begin pix_valid = 1; pix_data = p[idx < 9 ? idx : 8]; idx++; w = 0; end
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_data = $urandom;
            end
        end
        pix_valid = 0;
        chk({tag, " result"}, 64'(result), 64'(exp));
        chk({tag, " done cycle"}, 64'(done_cyc), 64'(24 + 9 * gap));
        chk({tag, " r13 writes"}, 64'(n13), 64'd9);
        chk({tag, " clr writes"}, 64'(nclr), 64'd1);
        chk({tag, " req cycles"}, 64'(nreq), 64'(9 * (gap + 1)));
        @(negedge clk);
        chk({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
    endtask

    typedef struct {
        logic [23:0] k;
        logic [23:0] p0, p1, p2;
        int          gap;
        bit          hold;
        logic [23:0] exp;
    } vec_t;

    function automatic logic [59:0] all_out();
        return {pix_req, rf_wrt_ena, rf_addrs_rd, rf_wrt_data, rf_addrs_rn, result, done, busy};
    endfunction

    initial begin
        vec_t        vt [4];
        logic [23:0] k [3], p [9], prev;
        int          idx, n, loads;
        vt[0] = '{24'h010101, 24'd10, 24'd20, 24'd30, 0, 0, 24'd180};
        vt[1] = '{24'h010000, 24'd16, 24'd16, 24'd16, 0, 0, 24'd60};
        vt[2] = '{24'h020103, 24'd5,  24'd7,  24'd9,  3, 0, 24'd132};
        vt[3] = '{24'h010101, 24'd10, 24'd20, 24'd30, 1, 1, 24'd180};

        #1 chk("reset outputs", 64'(all_out()), 64'd0);
        #20 rst_n = 1;

        for (int v = 0; v < 4; v++) begin
            for (int r = 0; r < 3; r++) begin
                k[r] = vt[v].k;
                p[3*r] = vt[v].p0; p[3*r+1] = vt[v].p1; p[3*r+2] = vt[v].p2;
            end
            do_job(k, p, vt[v].gap, vt[v].hold, vt[v].exp, $sformatf("vec%0d", v));
        end

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++)
                    k[r][23 - 8 * j -: 8] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            for (int i = 0; i < 9; i++) p[i] = 24'($urandom);
            do_job(k, p, $urandom_range(0, 2), 1'($urandom_range(0, 1)), ref_result(k, p),
                   $sformatf("rand%0d", t));
        end

        // START and ABORT together in IDLE: stay idle.
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("start+abort idle", {63'd0, busy}, 64'd0);

        // ABORT while waiting for the 5th pixel.
        prev = result;
        krow0 = 24'h010101; krow1 = 24'h010101; krow2 = 24'h010101;
        start = 1;
        idx = 0; n = 0;
        while (!(idx == 4 && pix_req) && n < 100) begin
            @(negedge clk);
            n++;
            start = 0;
            pix_valid = pix_req;
            pix_data = 24'd10;
            if (pix_req) idx++;
        end
        pix_valid = 0; abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort idle", {61'd0, busy, done, rf_wrt_ena}, 64'd0);
        chk("abort result", 64'(result), 64'(prev));
        n = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); n += int'(done); end
        chk("abort no done", 64'(n), 64'd0);
        for (int r = 0; r < 3; r++) begin k[r] = 24'h010101; p[3*r] = 10; p[3*r+1] = 20; p[3*r+2] = 30; end
        do_job(k, p, 0, 0, 24'd180, "after abort");

        // Reset during the second LOAD.
        start = 1;
        loads = 0; n = 0;
        while (loads < 2 && n < 100) begin
            @(negedge clk);
            n++;
            start = 0;
            pix_valid = 1;
            pix_data = 24'd7;
            if (rf_wrt_ena && rf_addrs_rd == R_KROW) loads++;
        end
        chk("reached 2nd load", 64'(loads), 64'd2);
        rst_n = 0;
        #1 chk("mid-job reset outputs", 64'(all_out()), 64'd0);
        @(negedge clk);
        rst_n = 1; pix_valid = 0;
        @(negedge clk);
        chk("post reset idle", {63'd0, busy}, 64'd0);
        do_job(k, p, 0, 1, 24'd180, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
